mp3_bit_packer: RTL and testbench

- MSB-first variable-length field packer; the writer counterpart of the Huffman decoder's bitstream reader.
- Accepts fields of 1..24 bits: header, side info and Huffman codewords.
- Packs them into bytes and writes the bytes into the main-data byte RAM through a single write port, starting at a programmable base address.
- Used by the loopback/self-test path to build frames that HUFFMANDECODER then consumes.

---
 rtl/mp3_bit_packer.sv | 199 +++++++++++++++++++
 tb/tb_mp3_bit_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp3_bit_packer.sv
// MSB-first variable-length field packer writing bytes into the main-data RAM.
// Optional MPEG CRC-16 over gated fields when MP3_PACK_CRC_EN is defined.
module mp3_bit_packer #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic        PAD_BIT = 1'b0
) (
`ifdef MP3_PACK_CRC_EN
  input  logic              crc_gate,
  output logic [15:0]       crc_out,
`endif
  input  logic              clock,
  input  logic              global_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              field_valid,
  output logic              field_ready,
  input  logic [23:0]       field_data,
  input  logic [4:0]        field_len,
  input  logic              flush,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_datain,
  output logic [ADDR_W:0]   byte_count,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q;
  logic [31:0]         acc_q;
  logic [4:0]          cnt_q;
  logic                flush_pend_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic [7:0]          ram_datain_q;
  logic [ADDR_W:0]     byte_count_q;
  logic                busy_q;
  logic                done_q;

  logic [4:0]          len_eff_s;
  logic [23:0]         field_mask_s;
  logic [5:0]          shamt_s;
  logic [31:0]         acc_app_d;
  logic [4:0]          cnt_app_d;
  logic [7:0]          pad_byte_s;
  logic                accept_s;

`ifdef MP3_PACK_CRC_EN
  logic [15:0]         crc_q;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [23:0] data,
                                               input logic [4:0]  len);
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (i < int'(len)) begin
        if (c[15] ^ data[i]) begin
          c = {c[14:0], 1'b0} ^ 16'h8005;
        end else begin
          c = {c[14:0], 1'b0};
        end
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  assign crc_out = crc_q;
`endif

  assign field_ready = (state_q == S_RUN) && (cnt_q < 5'd8) && !flush_pend_q;
  assign accept_s    = field_valid && field_ready;

  // Live bits sit left-justified in acc_q; a new field lands directly below them.
  always_comb begin
    if (field_len > 5'd24) begin
      len_eff_s = 5'd24;
    end else begin
      len_eff_s = field_len;
    end
    field_mask_s = 24'hFF_FFFF >> (5'd24 - len_eff_s);
    shamt_s      = 6'd32 - {1'b0, cnt_q} - {1'b0, len_eff_s};
    acc_app_d    = acc_q | ({8'h00, field_data & field_mask_s} << shamt_s);
    cnt_app_d    = cnt_q + len_eff_s;
  end

  // Final partial byte: bits below the live ones are stuffed with PAD_BIT.
  always_comb begin
    if (PAD_BIT) begin
      pad_byte_s = acc_q[31:24] | (8'hFF >> cnt_q);
    end else begin
      pad_byte_s = acc_q[31:24];
    end
  end

  // Frame control, byte emission and address/count bookkeeping.
  always_ff @(posedge clock or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= 32'h0000_0000;
      cnt_q         <= 5'd0;
      flush_pend_q  <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_address_q <= {ADDR_W{1'b0}};
      ram_datain_q  <= 8'h00;
      byte_count_q  <= {(ADDR_W+1){1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef MP3_PACK_CRC_EN
      crc_q         <= 16'hFFFF;
`endif
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      // Address and count advance the cycle after the strobe they describe.
      if (ram_we_q) begin
        ram_address_q <= ram_address_q + 1'b1;
        if (byte_count_q != COUNT_MAX) begin
          byte_count_q <= byte_count_q + 1'b1;
        end
      end
      if (start) begin
        state_q       <= S_RUN;
        acc_q         <= 32'h0000_0000;
        cnt_q         <= 5'd0;
        flush_pend_q  <= 1'b0;
        ram_address_q <= base_addr;
        byte_count_q  <= {(ADDR_W+1){1'b0}};
        busy_q        <= 1'b1;
`ifdef MP3_PACK_CRC_EN
        crc_q         <= 16'hFFFF;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_RUN: begin
            if (flush) begin
              flush_pend_q <= 1'b1;
            end
            if (cnt_q >= 5'd8) begin
              ram_we_q     <= 1'b1;
              ram_datain_q <= acc_q[31:24];
              acc_q        <= {acc_q[23:0], 8'h00};
              cnt_q        <= cnt_q - 5'd8;
            end else if (flush_pend_q) begin
              state_q <= S_FLUSH;
            end else if (accept_s) begin
              acc_q <= acc_app_d;
              cnt_q <= cnt_app_d;
`ifdef MP3_PACK_CRC_EN
              if (crc_gate) begin
                crc_q <= crc16_update(crc_q, field_data, len_eff_s);
              end
`endif
            end
          end
          S_FLUSH: begin
            if (cnt_q != 5'd0) begin
              ram_we_q     <= 1'b1;
              ram_datain_q <= pad_byte_s;
            end
            acc_q        <= 32'h0000_0000;
            cnt_q        <= 5'd0;
            flush_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_DONE;
          end
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_address = ram_address_q;
  assign ram_datain  = ram_datain_q;
  assign byte_count  = byte_count_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mp3_bit_packer.sv
// Bench for mp3_bit_packer: bit-queue reference model plus literal byte pins.
module tb_mp3_bit_packer;
  localparam int ADDR_W = 10;

  logic              clock = 1'b0;
  logic              global_rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              field_valid;
  logic              field_ready;
  logic [23:0]       field_data;
  logic [4:0]        field_len;
  logic              flush;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_datain;
  logic [ADDR_W:0]   byte_count;
  logic              busy;
  logic              done;
`ifdef MP3_PACK_CRC_EN
  logic              crc_gate;
  logic [15:0]       crc_out;
`endif

  int checks = 0;
  int errors = 0;

  bit              bitq[$];
  bit              crcq[$];
  logic [7:0]      exp_q[$];
  logic [17:0]     wlog[$];
  logic [ADDR_W-1:0] exp_addr;
  int              exp_bytes;
  logic [7:0]      cmp_b;
  int              nw;

  mp3_bit_packer #(.ADDR_W(ADDR_W), .PAD_BIT(1'b0)) dut (
`ifdef MP3_PACK_CRC_EN
    .crc_gate    (crc_gate),
    .crc_out     (crc_out),
`endif
    .clock       (clock),
    .global_rst_n(global_rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .field_valid (field_valid),
    .field_ready (field_ready),
    .field_data  (field_data),
    .field_len   (field_len),
    .flush       (flush),
    .ram_we      (ram_we),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .byte_count  (byte_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: bits stream into a queue; every 8 bits become one expected byte.
  task automatic model_push(input logic [23:0] d, input int len);
    int l;
    logic [7:0] b;
    l = (len > 24) ? 24 : len;
    for (int i = l - 1; i >= 0; i--) bitq.push_back(d[i]);
    while (bitq.size() >= 8) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
      exp_q.push_back(b);
      exp_bytes++;
    end
  endtask

  task automatic model_flush();
    while (bitq.size() % 8 != 0) bitq.push_back(1'b0);
    model_push(24'h0, 0);
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (crcq[i]) begin
      if (c[15] ^ crcq[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Every write strobe must match the next model byte at the next model address.
  always @(negedge clock) begin
    if (global_rst_n === 1'b1 && ram_we === 1'b1) begin
      chk("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cmp_b = exp_q.pop_front();
        chk("ram_datain", ram_datain, cmp_b);
        chk("ram_address", ram_address, exp_addr);
        exp_addr = exp_addr + 1'b1;
      end
      wlog.push_back({ram_address, ram_datain});
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] b);
    base_addr = b;
    start = 1'b1;
    bitq.delete(); exp_q.delete(); wlog.delete(); crcq.delete();
    exp_addr = b;
    exp_bytes = 0;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_field(input logic [23:0] d, input int len, input bit fl, output int nwait);
    int l;
    nwait = 0;
    field_valid = 1'b1;
    field_data = d;
    field_len = 5'(len);
    forever begin
      @(negedge clock);
      if (field_ready === 1'b1) break;
      nwait++;
      if (nwait > 40) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
    if (field_ready === 1'b1) begin
      flush = fl;
      model_push(d, len);
`ifdef MP3_PACK_CRC_EN
      if (crc_gate) begin
        l = (len > 24) ? 24 : len;
        for (int i = l - 1; i >= 0; i--) crcq.push_back(d[i]);
      end
`endif
      if (fl) model_flush();
    end
    @(posedge clock); #1;
    field_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_flush();
    @(posedge clock); #1;
    flush = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (done !== 1'b1 && n < 60);
    chk({tag, "_done"}, done, 1);
    @(negedge clock);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_byte_count"}, byte_count, exp_bytes);
    chk({tag, "_all_written"}, exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    global_rst_n = 1'b0;
    start = 1'b0; base_addr = '0; field_valid = 1'b0;
    field_data = 24'h0; field_len = 5'd0; flush = 1'b0;
    exp_addr = '0; exp_bytes = 0;
`ifdef MP3_PACK_CRC_EN
    crc_gate = 1'b0;
`endif
    @(negedge clock);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_address", ram_address, 0);
    chk("rst_ram_datain", ram_datain, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_field_ready", field_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clock); #1;
    global_rst_n = 1'b1;
    @(posedge clock); #1;

    // Two fields exactly filling two bytes: no pad byte.
    do_start(10'h010);
    chk("t1_busy", busy, 1);
    send_field(24'hFFF, 12, 1'b0, nw);
    send_field(24'hB, 4, 1'b0, nw);
    do_flush();
    wait_done("t1");
    chk("t1_nwrites", wlog.size(), 2);
    chk("t1_w0", wlog[0], {10'h010, 8'hFF});
    chk("t1_w1", wlog[1], {10'h011, 8'hFB});
    chk("t1_addr_after", ram_address, 10'h012);

    // Flush in the same cycle as the last field; partial byte padded.
    do_start(10'h020);
    send_field(24'h5, 3, 1'b0, nw);
    send_field(24'h1, 1, 1'b1, nw);
    wait_done("t2");
    chk("t2_nwrites", wlog.size(), 1);
    chk("t2_w0", wlog[0], {10'h020, 8'hB0});

    // Flush while idle is ignored.
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_nowrite", wlog.size(), 1);

    // Address wrap at the top of the RAM.
    do_start(10'h3FE);
    send_field(24'hABCDEF, 24, 1'b0, nw);
    send_field(24'h1, 8, 1'b0, nw);
    do_flush();
    wait_done("t3");
    chk("t3_nwrites", wlog.size(), 4);
    chk("t3_w0", wlog[0], {10'h3FE, 8'hAB});
    chk("t3_w1", wlog[1], {10'h3FF, 8'hCD});
    chk("t3_w2", wlog[2], {10'h000, 8'hEF});
    chk("t3_w3", wlog[3], {10'h001, 8'h01});
    chk("t3_addr_after", ram_address, 10'h002);

    // Excess data bits ignored, zero-length no-op, over-long length clamps to 24.
    do_start(10'h080);
    send_field(24'hABC5, 4, 1'b0, nw);
    send_field(24'h0, 0, 1'b0, nw);
    send_field(24'h123456, 31, 1'b0, nw);
    do_flush();
    wait_done("t4");
    chk("t4_nwrites", wlog.size(), 4);
    chk("t4_w0", wlog[0], {10'h080, 8'h51});
    chk("t4_w1", wlog[1], {10'h081, 8'h23});
    chk("t4_w2", wlog[2], {10'h082, 8'h45});
    chk("t4_w3", wlog[3], {10'h083, 8'h60});

    // Valid held with 24-bit fields: three drain cycles with ready low each time.
    do_start(10'h100);
    send_field(24'h5, 3, 1'b0, nw);
    send_field(24'hC3A5F0, 24, 1'b0, nw);
    chk("t5_wait_first", nw, 0);
    send_field(24'h0F1E2D, 24, 1'b0, nw);
    chk("t5_wait_2", nw, 3);
    send_field(24'h96B4D2, 24, 1'b0, nw);
    chk("t5_wait_3", nw, 3);
    send_field(24'h7E8181, 24, 1'b0, nw);
    chk("t5_wait_4", nw, 3);
    do_flush();
    wait_done("t5");
    chk("t5_nwrites", wlog.size(), 13);

    // Start mid-frame with 5 bits pending: dropped, new frame at new base.
    do_start(10'h200);
    send_field(24'h15, 5, 1'b0, nw);
    do_start(10'h040);
    send_field(24'hA5, 8, 1'b0, nw);
    do_flush();
    wait_done("t6");
    chk("t6_nwrites", wlog.size(), 1);
    chk("t6_w0", wlog[0], {10'h040, 8'hA5});

    // Reset while bytes are draining.
    do_start(10'h300);
    send_field(24'h123456, 24, 1'b0, nw);
    @(posedge clock); #1;
    global_rst_n = 1'b0;
    bitq.delete(); exp_q.delete();
    @(negedge clock);
    chk("mrst_ram_we", ram_we, 0);
    chk("mrst_ram_address", ram_address, 0);
    chk("mrst_ram_datain", ram_datain, 0);
    chk("mrst_byte_count", byte_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_field_ready", field_ready, 0);
    @(posedge clock); #1;
    global_rst_n = 1'b1;
    @(posedge clock); #1;
    do_start(10'h005);
    send_field(24'h3C, 8, 1'b1, nw);
    wait_done("t7");
    chk("t7_w0", wlog[0], {10'h005, 8'h3C});

`ifdef MP3_PACK_CRC_EN
    do_start(10'h000);
    chk("crc_init", crc_out, 16'hFFFF);
    crc_gate = 1'b1;
    send_field(24'hFFFB, 16, 1'b0, nw);
    send_field(24'h9000, 16, 1'b0, nw);
    crc_gate = 1'b0;
    @(negedge clock);
    chk("crc_header", crc_out, crc_ref());
    @(posedge clock); #1;
    send_field(24'h3, 2, 1'b0, nw);
    @(negedge clock);
    chk("crc_ungated_hold", crc_out, crc_ref());
    @(posedge clock); #1;
    do_flush();
    wait_done("crc");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
